// File: rtl/baud_rate_generator_programmable.sv
// Programmable square-wave baud generator: a restoring divider derives the half-period
// from clock/baud settings, and a phase counter drives ClockOut with phase strobes and burst mode.
module baud_rate_generator_programmable #(
  parameter int CF_WIDTH  = 30,
  parameter int BR_WIDTH  = 20,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic [BR_WIDTH-1:0]  BaudRate,
  input  logic [CF_WIDTH-1:0]  ClockFrequency,
  input  logic                 Enable,
  input  logic                 Burst,
  input  logic [CNT_WIDTH-1:0] BurstCount,
  output logic                 ClockOut,
  output logic                 RiseStrobe,
  output logic                 FallStrobe,
  output logic                 MidHighStrobe,
  output logic                 MidLowStrobe,
  output logic                 Ready,
  output logic                 Busy,
  output logic                 Done,
  output logic                 ConfigError
);

  localparam int DW  = BR_WIDTH + 1;
  localparam int BCW = $clog2(CF_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(CF_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  // Divider state
  logic                 r_ready;
  logic [BCW-1:0]       r_bcnt;
  logic [DW-1:0]        r_rem;
  logic [DW-1:0]        r_div;
  logic [CF_WIDTH-1:0]  r_quo;
  logic [CF_WIDTH-1:0]  r_half_period;
  logic                 r_config_error;

  logic [DW:0]          w_rem_sh;
  logic                 w_ge;
  logic [DW-1:0]        w_rem_sub;
  logic [CF_WIDTH-1:0]  w_quo_next;

  // Generator state
  state_t               r_state;
  state_t               w_state_next;
  logic [CF_WIDTH-1:0]  r_cnt;
  logic                 r_clk_out;
  logic                 r_burst;
  logic [CNT_WIDTH-1:0] r_left;
  logic                 r_rise;
  logic                 r_fall;
  logic                 r_done;

  logic                 w_start;
  logic                 w_zero_burst;
  logic                 w_terminal;
  logic                 w_last_fall;
  logic                 w_mid;

  // The low DW bits of the difference are exact whenever w_ge holds.
  assign w_rem_sh   = {r_rem, r_quo[CF_WIDTH-1]};
  assign w_ge       = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_sub  = w_rem_sh[DW-1:0] - r_div;
  assign w_quo_next = {r_quo[CF_WIDTH-2:0], w_ge};

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_ready        <= 1'b1;
      r_bcnt         <= '0;
      r_rem          <= '0;
      r_div          <= '0;
      r_quo          <= '0;
      r_half_period  <= '0;
      r_config_error <= 1'b0;
    end else if (r_ready) begin
      if (Load) begin
        r_ready <= 1'b0;
        r_bcnt  <= '0;
        r_rem   <= '0;
        r_div   <= {BaudRate, 1'b0};
        r_quo   <= ClockFrequency;
      end
    end else begin
      r_rem  <= w_ge ? w_rem_sub : w_rem_sh[DW-1:0];
      r_quo  <= w_quo_next;
      r_bcnt <= r_bcnt + BCW'(1);
      if (r_bcnt == LAST_BIT) begin
        r_ready <= 1'b1;
        if ((r_div == '0) || (w_quo_next == '0)) begin
          r_config_error <= 1'b1;
        end else begin
          r_half_period  <= w_quo_next;
          r_config_error <= 1'b0;
        end
      end
    end
  end

  assign w_start      = Enable && (r_half_period != '0);
  assign w_zero_burst = Burst && (BurstCount == '0);
  // >= rather than == so a shrinking reload ends the phase immediately
  assign w_terminal   = (r_cnt >= (r_half_period - CF_WIDTH'(1)));
  assign w_last_fall  = w_terminal && r_clk_out && r_burst && (r_left == CNT_WIDTH'(1));
  assign w_mid        = (r_cnt == (r_half_period >> 1));

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = w_zero_burst ? S_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        if (!Enable) begin
          w_state_next = S_IDLE;
        end else if (w_last_fall) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!Enable) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
      r_burst   <= 1'b0;
      r_left    <= '0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_burst   <= Burst;
            r_left    <= BurstCount;
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_done    <= w_zero_burst;
          end
        end
        S_RUN: begin
          if (!Enable) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
          end else if (w_terminal) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            if (r_clk_out) begin
              r_fall <= 1'b1;
              if (r_burst) begin
                r_left <= r_left - CNT_WIDTH'(1);
                r_done <= (r_left == CNT_WIDTH'(1));
              end
            end else begin
              r_rise <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CF_WIDTH'(1);
          end
        end
        default: begin
          r_cnt     <= '0;
          r_clk_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    Busy          = (r_state == S_RUN);
    ClockOut      = r_clk_out;
    RiseStrobe    = r_rise;
    FallStrobe    = r_fall;
    MidHighStrobe = Busy && r_clk_out && w_mid;
    MidLowStrobe  = Busy && !r_clk_out && w_mid;
    Ready         = r_ready;
    Done          = r_done;
    ConfigError   = r_config_error;
  end

endmodule

// File: tb/tb_baud_rate_generator_programmable.sv
// Directed bench for baud_rate_generator_programmable; observation vector is
// {ClockOut, RiseStrobe, FallStrobe, MidHighStrobe, MidLowStrobe, Busy, Done}.
module tb_baud_rate_generator_programmable;

  logic        clock = 1'b0;
  logic        Reset;
  logic        Load;
  logic [19:0] BaudRate;
  logic [29:0] ClockFrequency;
  logic        Enable;
  logic        Burst;
  logic [15:0] BurstCount;
  logic        ClockOut, RiseStrobe, FallStrobe, MidHighStrobe, MidLowStrobe;
  logic        Ready, Busy, Done, ConfigError;

  int compared   = 0;
  int mismatched = 0;

  baud_rate_generator_programmable #(
    .CF_WIDTH(30), .BR_WIDTH(20), .CNT_WIDTH(16)
  ) dut (
    .clock(clock), .Reset(Reset), .Load(Load), .BaudRate(BaudRate),
    .ClockFrequency(ClockFrequency), .Enable(Enable), .Burst(Burst),
    .BurstCount(BurstCount), .ClockOut(ClockOut), .RiseStrobe(RiseStrobe),
    .FallStrobe(FallStrobe), .MidHighStrobe(MidHighStrobe),
    .MidLowStrobe(MidLowStrobe), .Ready(Ready), .Busy(Busy), .Done(Done),
    .ConfigError(ConfigError)
  );

  always #5 clock = ~clock;

  function automatic logic [6:0] ov();
    return {ClockOut, RiseStrobe, FallStrobe, MidHighStrobe, MidLowStrobe, Busy, Done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [19:0] br, input logic [29:0] cf);
    int n;
    @(negedge clock);
    Load = 1'b1; BaudRate = br; ClockFrequency = cf;
    @(negedge clock);
    Load = 1'b0;
    n = 0;
    while (!Ready && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("load_ready", 32'(Ready), 32'd1);
  endtask

  // HalfPeriod=2 continuous pattern, cycles 1..8 after start
  logic [6:0] hp2_tab [8] = '{7'b0000010, 7'b0000110, 7'b1100010, 7'b1001010,
                              7'b0010010, 7'b0000110, 7'b1100010, 7'b1001010};
  // HalfPeriod=1 pattern, cycles 1..4 after start
  logic [6:0] hp1_tab [4] = '{7'b0000110, 7'b1101010, 7'b0010110, 7'b1101010};

  initial begin
    int n, rises, falls, dones, done_k;
    logic busy12, fall13, busy13, out_after;
    logic exp_out;

    Reset = 1'b0; Load = 1'b0; Enable = 1'b0; Burst = 1'b0;
    BaudRate = '0; ClockFrequency = '0; BurstCount = '0;
    repeat (2) @(negedge clock);
    chk("reset_outs", 32'(ov()), 32'd0);
    chk("reset_ready", 32'(Ready), 32'd1);
    chk("reset_cfgerr", 32'(ConfigError), 32'd0);
    Reset = 1'b1;
    @(negedge clock);

    // First divide: Ready low for exactly 30 cycles; a Load mid-divide is ignored
    Load = 1'b1; BaudRate = 20'd2; ClockFrequency = 30'd10;
    @(negedge clock);
    Load = 1'b0;
    n = 0;
    while (!Ready && n < 100) begin
      n++;
      if (n == 10) begin Load = 1'b1; BaudRate = 20'd0; end
      else Load = 1'b0;
      @(negedge clock);
    end
    chk("div_latency", 32'(n), 32'd30);
    chk("cfg_ok", 32'(ConfigError), 32'd0);

    // Continuous, HalfPeriod=2
    Enable = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      chk("cont_hp2", 32'(ov()), 32'(hp2_tab[(k <= 8) ? k - 1 : k - 5]));
    end
    // Drop Enable during second high cycle
    Enable = 1'b0;
    @(negedge clock);
    chk("drop_next", 32'(ov()), 32'd0);
    @(negedge clock);
    chk("drop_idle", 32'(ov()), 32'd0);
    Enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("reenable", 32'(ov()), 32'(hp2_tab[k - 1]));
    end
    Enable = 1'b0;
    @(negedge clock);

    // Configuration errors keep HalfPeriod=2
    do_load(20'd0, 30'd10);
    chk("cfg_br0", 32'(ConfigError), 32'd1);
    do_load(20'd2, 30'd3);
    chk("cfg_q0", 32'(ConfigError), 32'd1);
    Enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("hp_kept", 32'(ov()), 32'(hp2_tab[k - 1]));
    end
    Enable = 1'b0;
    @(negedge clock);
    do_load(20'd1, 30'd10);
    chk("cfg_clear", 32'(ConfigError), 32'd0);

    // HalfPeriod 5 -> 2 reload committing while cnt goes 3->4 in a high phase
    @(negedge clock);
    Load = 1'b1; BaudRate = 20'd2; ClockFrequency = 30'd10;
    @(negedge clock);
    Load = 1'b0; Enable = 1'b1;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clock);
      exp_out = (k <= 30) ? 1'(((k - 1) / 5) % 2) : 1'(((k - 31) / 2) % 2);
      chk("shrink_out", 32'(ClockOut), 32'(exp_out));
      if (k == 29) chk("shrink_rdy_lo", 32'(Ready), 32'd0);
      if (k == 30) chk("shrink_rdy_hi", 32'(Ready), 32'd1);
      if (k == 31) chk("shrink_fall", 32'(FallStrobe), 32'd1);
    end
    Enable = 1'b0;
    @(negedge clock);

    // HalfPeriod=1: 10/(2*5)
    do_load(20'd5, 30'd10);
    Enable = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk("hp1", 32'(ov()), 32'(hp1_tab[k - 1]));
    end
    Enable = 1'b0;
    @(negedge clock);

    // Burst of 3 at HalfPeriod=2
    do_load(20'd2, 30'd10);
    Burst = 1'b1; BurstCount = 16'd3; Enable = 1'b1;
    rises = 0; falls = 0; dones = 0; done_k = 0;
    busy12 = 1'b0; fall13 = 1'b0; busy13 = 1'b1; out_after = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      rises += int'(RiseStrobe);
      falls += int'(FallStrobe);
      dones += int'(Done);
      if (Done) done_k = k;
      if (k == 12) busy12 = Busy;
      if (k == 13) begin fall13 = FallStrobe; busy13 = Busy; end
      if (k >= 13 && ClockOut) out_after = 1'b1;
    end
    chk("burst_rises", 32'(rises), 32'd3);
    chk("burst_falls", 32'(falls), 32'd3);
    chk("burst_dones", 32'(dones), 32'd1);
    chk("burst_done_at", 32'(done_k), 32'd13);
    chk("burst_busy12", 32'(busy12), 32'd1);
    chk("burst_fall13", 32'(fall13), 32'd1);
    chk("burst_busy13", 32'(busy13), 32'd0);
    chk("burst_out_low", 32'(out_after), 32'd0);
    Enable = 1'b0;
    @(negedge clock);

    // Burst N=0: Done only
    BurstCount = 16'd0; Enable = 1'b1;
    @(negedge clock);
    chk("n0_done", 32'(ov()), 32'b0000001);
    @(negedge clock);
    chk("n0_after", 32'(ov()), 32'd0);
    @(negedge clock);
    chk("n0_idle", 32'(ov()), 32'd0);
    Enable = 1'b0;
    @(negedge clock);

    // Asynchronous reset mid-burst
    BurstCount = 16'd5; Enable = 1'b1;
    repeat (7) @(negedge clock);
    chk("burst_running", 32'(Busy), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("rst_burst_outs", 32'(ov()), 32'd0);
    chk("rst_burst_ready", 32'(Ready), 32'd1);
    chk("rst_burst_cfg", 32'(ConfigError), 32'd0);
    @(negedge clock);
    Reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("no_run_hp0", 32'(Busy), 32'd0);

    // Asynchronous reset mid-divide
    Load = 1'b1; BaudRate = 20'd1; ClockFrequency = 30'd10;
    @(negedge clock);
    Load = 1'b0;
    repeat (10) @(negedge clock);
    chk("mid_div_busy", 32'(Ready), 32'd0);
    #2 Reset = 1'b0;
    #1;
    chk("rst_div_ready", 32'(Ready), 32'd1);
    @(negedge clock);
    Reset = 1'b1;
    repeat (40) @(negedge clock);
    chk("aborted_no_run", 32'(Busy), 32'd0);

    // Run starts when HalfPeriod becomes nonzero with Enable held
    Burst = 1'b0;
    do_load(20'd2, 30'd10);
    chk("commit_cycle_idle", 32'(Busy), 32'd0);
    @(negedge clock);
    chk("hp_nonzero_start", 32'(ov()), 32'(hp2_tab[0]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
